// File: rtl/key_debouncer_pkg.sv
// Shared types and sizing helpers for the front-panel key debouncer.
// Holds the per-key FSM state encoding and width/divider arithmetic.
// No logic lives here.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } key_state_t;

  // Number of Clk cycles between debounce samples.
  function automatic int calc_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int width_for(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, sample-driven debounce FSM, registered level and pulses.
// Latency: 2 sync cycles + wait to next Tick + (STABLE_SAMPLES-1) Ticks + 1 output edge.
// No backpressure: pulses are single-cycle and unconditional, the consumer must take them.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_SAMPLES = 20
) (
  input  logic Clk,
  input  logic nReset,
  input  logic Tick,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = width_for(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_SAMPLES);

  logic          sync1;
  logic          sync2;
  logic          s;
  key_state_t    state;
  logic [CW-1:0] cnt;

  // Bring the raw active-low switch into the Clk domain; reset to "released".
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  // Debounce FSM: advances only on Tick; level and pulses are registered here so
  // the level is glitch-free and rises on the same edge as the press pulse.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state         <= RELEASED;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (Tick) begin
        unique case (state)
          RELEASED: begin
            if (s) begin
              if (STABLE_SAMPLES == 1) begin
                state       <= PRESSED;
                level       <= 1'b1;
                press_pulse <= 1'b1;
              end else begin
                state <= PRESS_PENDING;
                cnt   <= CNT_ONE;
              end
            end
          end
          PRESS_PENDING: begin
            if (!s) begin
              // Bounce: discard the partial run.
              state <= RELEASED;
              cnt   <= '0;
            end else if ((cnt + CNT_ONE) == CNT_DONE) begin
              state       <= PRESSED;
              cnt         <= '0;
              level       <= 1'b1;
              press_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!s) begin
              if (STABLE_SAMPLES == 1) begin
                state         <= RELEASED;
                level         <= 1'b0;
                release_pulse <= 1'b1;
              end else begin
                state <= RELEASE_PENDING;
                cnt   <= CNT_ONE;
              end
            end
          end
          RELEASE_PENDING: begin
            if (s) begin
              // Level stays high: the key never left the held state.
              state <= PRESSED;
              cnt   <= '0;
            end else if ((cnt + CNT_ONE) == CNT_DONE) begin
              state         <= RELEASED;
              cnt           <= '0;
              level         <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Front-panel key debouncer: shared sample prescaler plus one debounce channel per key.
// Latency: 2 sync cycles + 0..DIV-1 wait + (STABLE_SAMPLES-1)*DIV cycles + 1 output edge.
// No backpressure: Pressed is a level, Press/Release/Tick are single-cycle strobes.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N_KEYS         = 4,
  parameter int CLK_HZ         = 50_000_000,
  parameter int SAMPLE_HZ      = 1_000,
  parameter int STABLE_SAMPLES = 20
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic [N_KEYS-1:0] Key_n,
  output logic [N_KEYS-1:0] Pressed,
  output logic [N_KEYS-1:0] Press,
  output logic [N_KEYS-1:0] Release,
  output logic              Tick
);

  localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int PW  = width_for(DIV);
  localparam logic [PW-1:0] RELOAD = PW'(DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick_q;

  // Down-counting prescaler; Tick is registered off the terminal count so the
  // first strobe lands DIV cycles after reset release and repeats every DIV cycles.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pre_cnt <= RELOAD;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= (pre_cnt == '0);
      if (pre_cnt == '0) begin
        pre_cnt <= RELOAD;
      end else begin
        pre_cnt <= pre_cnt - PW'(1);
      end
    end
  end

  assign Tick = tick_q;

  genvar k;
  generate
    for (k = 0; k < N_KEYS; k++) begin : g_key
      key_debounce_channel #(
        .STABLE_SAMPLES (STABLE_SAMPLES)
      ) u_chan (
        .Clk           (Clk),
        .nReset        (nReset),
        .Tick          (tick_q),
        .key_n         (Key_n[k]),
        .level         (Pressed[k]),
        .press_pulse   (Press[k]),
        .release_pulse (Release[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with a pulse scoreboard.
// Expected pulse cycles are derived from the documented latency formula.
// Tick timing and level/pulse alignment are checked every cycle.
module tb_key_debouncer;

  localparam int N      = 4;
  localparam int DIV    = 10;
  localparam int STABLE = 4;

  typedef struct {
    int       cyc;
    logic [3:0] press;
    logic [3:0] rel;
  } exp_t;

  logic         Clk;
  logic         nReset;
  logic [N-1:0] Key_n;
  logic [N-1:0] Pressed;
  logic [N-1:0] Press;
  logic [N-1:0] Release;
  logic         Tick;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  exp_t sb[$];
  logic [N-1:0] prev_pressed;

  key_debouncer #(
    .N_KEYS         (N),
    .CLK_HZ         (1000),
    .SAMPLE_HZ      (100),
    .STABLE_SAMPLES (STABLE)
  ) dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .Key_n   (Key_n),
    .Pressed (Pressed),
    .Press   (Press),
    .Release (Release),
    .Tick    (Tick)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Rising edges since the last reset release.
  always @(posedge Clk or negedge nReset) begin
    if (!nReset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Edge on which a pulse appears for a raw change driven at the negedge where cyc == c:
  // 2 sync edges, then the first Tick-driven update that sees it, plus STABLE-1 more Ticks.
  function automatic int exp_edge(input int c);
    return DIV * ((c + 2 + DIV - 1) / DIV) + DIV * (STABLE - 1) + 1;
  endfunction

  function automatic exp_t mk(input int c, input logic [3:0] p, input logic [3:0] r);
    exp_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    return e;
  endfunction

  // Monitor: Tick period, unexpected pulses, scoreboard matching, level/pulse alignment.
  always @(negedge Clk) begin
    exp_t e;
    if (nReset === 1'b1) begin
      n_tests++;
      assert (Tick === ((cyc % DIV == 0) && (cyc != 0))) else begin
        n_fail++;
        $error("FAIL tick cyc=%0d observed=%b expected=%b", cyc, Tick, (cyc % DIV == 0) && (cyc != 0));
      end
      if (Press !== '0 || Release !== '0) begin
        n_tests++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_pulse cyc=%0d press=%h release=%h expected none", cyc, Press, Release);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_tests++;
          assert (cyc == e.cyc && Press === e.press && Release === e.rel) else begin
            n_fail++;
            $error("FAIL pulse observed cyc=%0d press=%h release=%h expected cyc=%0d press=%h release=%h",
                   cyc, Press, Release, e.cyc, e.press, e.rel);
          end
          n_tests++;
          assert (((Pressed & Press) === Press) && ((prev_pressed & Press) === '0) &&
                  ((Pressed & Release) === '0)) else begin
            n_fail++;
            $error("FAIL level_align cyc=%0d pressed=%h prev=%h press=%h release=%h",
                   cyc, Pressed, prev_pressed, Press, Release);
          end
        end
      end
      prev_pressed = Pressed;
    end else begin
      prev_pressed = '0;
    end
  end

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3 * DIV; k++) begin
      @(negedge Clk);
      if (Tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL tick_timeout observed=none expected=tick within %0d cycles", 3 * DIV);
    end
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 * DIV; k++) begin
      @(negedge Clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    @(negedge Clk);
    n_tests++;
    assert (done) else begin
      n_fail++;
      $error("FAIL %s drain observed=%0d pending expected=0", tag, sb.size());
    end
  endtask

  task automatic check_level(input string tag, input logic [3:0] exp);
    n_tests++;
    assert (Pressed === exp) else begin
      n_fail++;
      $error("FAIL %s pressed observed=%h expected=%h", tag, Pressed, exp);
    end
  endtask

  initial begin
    // 1. Reset state, then idle.
    nReset = 1'b0;
    Key_n  = 4'hF;
    repeat (3) @(negedge Clk);
    n_tests++;
    assert ({Pressed, Press, Release, Tick} === 13'd0) else begin
      n_fail++;
      $error("FAIL reset_outputs observed=%h expected=0", {Pressed, Press, Release, Tick});
    end
    nReset = 1'b1;
    repeat (35) @(negedge Clk);
    check_level("idle", 4'h0);

    // 2. Clean press and release of key 0.
    Key_n[0] = 1'b0;
    sb.push_back(mk(exp_edge(cyc), 4'h1, 4'h0));
    wait_drain("press0");
    check_level("held0", 4'h1);
    Key_n[0] = 1'b1;
    sb.push_back(mk(exp_edge(cyc), 4'h0, 4'h1));
    wait_drain("release0");
    check_level("after_release0", 4'h0);

    // 3. Key 1 bounces on alternate samples, then settles pressed.
    wait_tick();
    for (int i = 0; i < 10; i++) begin
      Key_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_tick();
    end
    check_level("bounce1", 4'h0);
    Key_n[1] = 1'b0;
    sb.push_back(mk(exp_edge(cyc), 4'h2, 4'h0));
    wait_drain("settle1");
    check_level("held1", 4'h2);
    Key_n[1] = 1'b1;
    sb.push_back(mk(exp_edge(cyc), 4'h0, 4'h2));
    wait_drain("release1");

    // 4. All four keys pressed in the same cycle.
    Key_n = 4'h0;
    sb.push_back(mk(exp_edge(cyc), 4'hF, 4'h0));
    wait_drain("press_all");
    check_level("held_all", 4'hF);
    Key_n = 4'b1110;
    sb.push_back(mk(exp_edge(cyc), 4'h0, 4'hE));
    wait_drain("release_123");
    check_level("only0", 4'h1);

    // 5. Reset while key 2 has three agreeing samples.
    wait_tick();
    Key_n = 4'b1010;
    wait_tick();
    wait_tick();
    wait_tick();
    repeat (2) @(negedge Clk);
    check_level("pending2", 4'h1);
    nReset = 1'b0;
    #1;
    n_tests++;
    assert ({Pressed, Press, Release, Tick} === 13'd0) else begin
      n_fail++;
      $error("FAIL mid_reset observed=%h expected=0", {Pressed, Press, Release, Tick});
    end
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    sb.push_back(mk(exp_edge(0), 4'h5, 4'h0));
    wait_drain("fresh_press");
    check_level("after_reset", 4'h5);
    Key_n = 4'hF;
    sb.push_back(mk(exp_edge(cyc), 4'h0, 4'h5));
    wait_drain("release_02");

    // 6. One-cycle glitch on key 0 between samples.
    wait_tick();
    repeat (3) @(negedge Clk);
    Key_n[0] = 1'b0;
    @(negedge Clk);
    Key_n[0] = 1'b1;
    repeat (6 * DIV) @(negedge Clk);
    check_level("glitch", 4'h0);
    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
